bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake, buffers up to one word behind the word currently shifting, and emits one bit per clock on `ser_out`, which drives the detector's serial input `i`. Back-to-back words stream with no idle gap. A sticky underrun flag reports gaps in a continuous stream.

---
 rtl/bit_serializer.sv | 116 +++++++++++
 tb/tb_bit_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector: valid/ready word input,
// one-word holding register, one bit per clock on ser_out with a sticky underrun flag.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    input  logic             stream_en,
    output logic             underrun,
    input  logic             clr_underrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    bit_cnt;

    logic             accept;
    logic             last_bit;
    logic             word_gap;
    logic             out_bit;
    logic [WIDTH-1:0] shifted;

    assign in_ready = ~hold_full;
    assign accept   = in_valid & in_ready;
    assign last_bit = (bit_cnt == LAST_CNT);

    // A word finishing with nothing queued behind it leaves a hole in the stream.
    assign word_gap = (state == SHIFT) && last_bit && !hold_full && !accept;

    generate
        if (MSB_FIRST) begin : g_msb
            assign out_bit = shreg[WIDTH-1];
            assign shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign out_bit = shreg[0];
            assign shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    assign ser_valid = (state == SHIFT);
    assign ser_out   = (state == SHIFT) ? out_bit : 1'b0;
    assign busy      = (state == SHIFT) || hold_full;

    // On the last bit the held word wins over a fresh input word, which in turn
    // bypasses the holding register so back-to-back words leave no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end else if (accept) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (accept) begin
                            hold      <= in_data;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (accept) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun <= 1'b0;
        end else if (word_gap && stream_en) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed vector table, hand-written corner
// sequences and a randomized run against a bit-queue reference model.
module tb_bit_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             stream_en = 1'b0;
    logic             underrun;
    logic             clr_underrun = 1'b0;

    logic [WIDTH-1:0] lsb_in_data = '0;
    logic             lsb_in_valid = 1'b0;
    logic             lsb_in_ready;
    logic             lsb_ser_out;
    logic             lsb_ser_valid;
    logic             lsb_busy;
    logic             lsb_underrun;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             exp_out;
        logic             exp_valid;
        logic             exp_ready;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[$];

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .busy         (busy),
        .stream_en    (stream_en),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .in_data      (lsb_in_data),
        .in_valid     (lsb_in_valid),
        .in_ready     (lsb_in_ready),
        .ser_out      (lsb_ser_out),
        .ser_valid    (lsb_ser_valid),
        .busy         (lsb_busy),
        .stream_en    (1'b0),
        .underrun     (lsb_underrun),
        .clr_underrun (1'b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic check_output(input string tag, input logic e_out, input logic e_valid,
                                input logic e_ready, input logic e_busy, input logic e_under);
        check({tag, ".ser_out"},   {31'd0, ser_out},   {31'd0, e_out});
        check({tag, ".ser_valid"}, {31'd0, ser_valid}, {31'd0, e_valid});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ready});
        check({tag, ".busy"},      {31'd0, busy},      {31'd0, e_busy});
        check({tag, ".underrun"},  {31'd0, underrun},  {31'd0, e_under});
    endtask

    // Drives inputs at a falling edge and returns at the next falling edge.
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d,
                                  input logic se, input logic clr);
        in_valid     = v;
        in_data      = d;
        stream_en    = se;
        clr_underrun = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid     = 1'b0;
        stream_en    = 1'b0;
        clr_underrun = 1'b0;
        lsb_in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic void add_vec(input logic v, input logic [WIDTH-1:0] d, input logic e_out,
                                    input logic e_valid, input logic e_ready, input logic e_busy);
        vec_t r;
        r.valid     = v;
        r.data      = d;
        r.exp_out   = e_out;
        r.exp_valid = e_valid;
        r.exp_ready = e_ready;
        r.exp_busy  = e_busy;
        vecs.push_back(r);
    endfunction

    initial begin
        logic lsb_seq [WIDTH];
        logic model_q [$];
        logic model_under;

        // B0 streamed, 5A parked in hold, then 3C bypassing hold on the last bit of 5A.
        add_vec(1, 8'hB0, 1, 1, 1, 1);
        add_vec(1, 8'h5A, 0, 1, 0, 1);
        add_vec(0, 8'h00, 1, 1, 0, 1);
        add_vec(0, 8'h00, 1, 1, 0, 1);
        add_vec(0, 8'h00, 0, 1, 0, 1);
        add_vec(0, 8'h00, 0, 1, 0, 1);
        add_vec(0, 8'h00, 0, 1, 0, 1);
        add_vec(0, 8'h00, 0, 1, 0, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(1, 8'h3C, 0, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 0, 1, 1, 1);
        add_vec(0, 8'h00, 0, 0, 1, 0);
        add_vec(0, 8'h00, 0, 0, 1, 0);

        lsb_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset", 0, 0, 1, 0, 0);
        check("reset.lsb_ser_valid", {31'd0, lsb_ser_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_output("idle_after_reset", 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].data, 1'b0, 1'b0);
            check_output($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                         vecs[i].exp_ready, vecs[i].exp_busy, 1'b0);
        end

        // LSB-first instance sends 0D as 1,0,1,1,0,0,0,0.
        lsb_in_data  = 8'h0D;
        lsb_in_valid = 1'b1;
        @(negedge clk);
        lsb_in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("lsb_bit%0d", i), {31'd0, lsb_ser_out}, {31'd0, lsb_seq[i]});
            check($sformatf("lsb_valid%0d", i), {31'd0, lsb_ser_valid}, 32'd1);
            @(negedge clk);
        end
        check("lsb_done.ser_valid", {31'd0, lsb_ser_valid}, 32'd0);
        check("lsb_done.ser_out", {31'd0, lsb_ser_out}, 32'd0);

        // Underrun: sticky set, clear, set beating clear, and no set without stream_en.
        apply_stimulus(1, 8'hAA, 1, 0);
        repeat (7) apply_stimulus(0, 8'h00, 1, 0);
        check_output("und_lastbit", 0, 1, 1, 1, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        check_output("und_set", 0, 0, 1, 0, 1);
        repeat (3) apply_stimulus(0, 8'h00, 1, 0);
        check_output("und_sticky", 0, 0, 1, 0, 1);
        apply_stimulus(0, 8'h00, 1, 1);
        check_output("und_clear", 0, 0, 1, 0, 0);
        apply_stimulus(1, 8'h55, 1, 1);
        repeat (8) apply_stimulus(0, 8'h00, 1, 1);
        check_output("und_set_wins", 0, 0, 1, 0, 1);
        apply_stimulus(0, 8'h00, 0, 1);
        check_output("und_clear2", 0, 0, 1, 0, 0);
        apply_stimulus(1, 8'hAA, 0, 0);
        repeat (8) apply_stimulus(0, 8'h00, 0, 0);
        check_output("und_disabled", 0, 0, 1, 0, 0);

        // Reset at bit 3 with a word parked in hold; nothing may survive it.
        apply_stimulus(1, 8'hC3, 0, 0);
        apply_stimulus(1, 8'h96, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        check_output("pre_reset", 1'b0, 1, 0, 1, 0);
        #2 rst = 1'b0;
        #1 check_output("async_reset", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(1, 8'hFF, 0, 0);
        for (int i = 0; i < WIDTH; i++) begin
            check_output($sformatf("ff_bit%0d", i), 1, 1, 1, 1, 0);
            apply_stimulus(0, 8'h00, 0, 0);
        end
        check_output("ff_done", 0, 0, 1, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        check_output("ff_no_residue", 0, 0, 1, 0, 0);

        // Randomized run: the model is the queue of bits still owed on ser_out.
        do_reset();
        model_q.delete();
        model_under = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic             e_valid;
            logic             e_ready;
            logic             v;
            logic             se;
            logic             clr;
            logic             acc;
            logic             gap;
            logic [WIDTH-1:0] d;
            int               density;

            e_valid = (model_q.size() > 0);
            e_ready = (model_q.size() <= WIDTH);
            check_output($sformatf("rnd%0d", cyc), e_valid ? model_q[0] : 1'b0, e_valid,
                         e_ready, e_valid, model_under);

            density = (cyc / 250) % 3;
            case (density)
                0:       v = ($urandom_range(0, 7) == 0);
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            d   = WIDTH'($urandom);
            se  = ((cyc / 500) % 2) == 1;
            clr = ($urandom_range(0, 31) == 0);
            acc = v && e_ready;

            in_valid     = v;
            in_data      = d;
            stream_en    = se;
            clr_underrun = clr;

            @(posedge clk);
            gap = (model_q.size() == 1) && !acc;
            if (model_q.size() > 0) void'(model_q.pop_front());
            if (acc) begin
                for (int b = WIDTH - 1; b >= 0; b--) model_q.push_back(d[b]);
            end
            if (gap && se) model_under = 1'b1;
            else if (clr) model_under = 1'b0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
